fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 30 +++
 rtl/fetch_decode.sv | 20 ++
 rtl/fetch_controller.sv | 140 ++++++++++++++
 tb/tb_fetch_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// instruction-word field positions and datapath widths.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ_INSTR = 2'd1,
    ST_REQ_IMM   = 2'd2,
    ST_ISSUE     = 2'd3
  } fetch_state_t;

  localparam int WORD_W    = 32;
  localparam int OPCODE_W  = 5;
  localparam int REG_W     = 4;
  localparam int CNT_W     = 16;

  localparam int OPCODE_LSB = 27;
  localparam int S1_LSB     = 23;
  localparam int S2_LSB     = 19;
  localparam int DEST_LSB   = 15;

  localparam int IMM_FLAG_BIT = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic is_imm_opcode(input logic [OPCODE_W-1:0] opcode);
    return opcode[IMM_FLAG_BIT];
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Pure field extraction from the upper part of an instruction word; the
// low bits below the dest field carry no meaning and are not brought in.
module fetch_decode
  import fetch_controller_pkg::*;
(
  input  logic [WORD_W-1:DEST_LSB] i_word_hi,
  output logic [OPCODE_W-1:0]      o_opcode,
  output logic [REG_W-1:0]         o_s1,
  output logic [REG_W-1:0]         o_s2,
  output logic [REG_W-1:0]         o_dest,
  output logic                     o_is_imm
);

  assign o_opcode = i_word_hi[OPCODE_LSB +: OPCODE_W];
  assign o_s1     = i_word_hi[S1_LSB     +: REG_W];
  assign o_s2     = i_word_hi[S2_LSB     +: REG_W];
  assign o_dest   = i_word_hi[DEST_LSB   +: REG_W];
  assign o_is_imm = is_imm_opcode(o_opcode);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: fetches one- or two-word instructions,
// decodes them and holds each one until downstream accepts or a flush redirects.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter logic [CNT_W-1:0]  ISSUE_CNT_INIT = '0
) (
  input  logic              clk_r,
  input  logic              reset_n_r,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              valid_out,
  output logic [4:0]        opcode_out,
  output logic [3:0]        s1_out,
  output logic [3:0]        s2_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       ime_data_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       issue_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_pc_out;
  logic [OPCODE_W-1:0] r_opcode;
  logic [REG_W-1:0]    r_s1;
  logic [REG_W-1:0]    r_s2;
  logic [REG_W-1:0]    r_dest;
  logic [WORD_W-1:0]   r_imm;
  logic                r_valid;
  logic [CNT_W-1:0]    r_issue_cnt;

  logic [OPCODE_W-1:0] w_dec_opcode;
  logic [REG_W-1:0]    w_dec_s1;
  logic [REG_W-1:0]    w_dec_s2;
  logic [REG_W-1:0]    w_dec_dest;
  logic                w_dec_is_imm;
  logic                w_flush;
  logic                w_ack;
  logic                w_issue_fire;

  fetch_decode u_decode (
    .i_word_hi (imem_data[WORD_W-1:DEST_LSB]),
    .o_opcode  (w_dec_opcode),
    .o_s1      (w_dec_s1),
    .o_s2      (w_dec_s2),
    .o_dest    (w_dec_dest),
    .o_is_imm  (w_dec_is_imm)
  );

  // A flush outranks everything, so an acknowledge landing in the same
  // cycle is thrown away rather than captured.
  assign w_flush      = flush_in && (r_state != ST_IDLE);
  assign imem_req     = (r_state == ST_REQ_INSTR) || (r_state == ST_REQ_IMM);
  assign w_ack        = imem_ack && imem_req && !w_flush;
  assign w_issue_fire = (r_state == ST_ISSUE) && !stall_in && !w_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_r or negedge reset_n_r) begin
    if (!reset_n_r) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the next-state default is assigned before the case so every path
  // drives it and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      w_next_state = ST_REQ_INSTR;
      ST_REQ_INSTR: if (w_ack) w_next_state = w_dec_is_imm ? ST_REQ_IMM : ST_ISSUE;
      ST_REQ_IMM:   if (w_ack) w_next_state = ST_ISSUE;
      ST_ISSUE:     if (!stall_in) w_next_state = ST_REQ_INSTR;
      default:      w_next_state = ST_IDLE;
    endcase
    if (w_flush) w_next_state = ST_REQ_INSTR;
  end

  always_ff @(posedge clk_r or negedge reset_n_r) begin
    if (!reset_n_r) begin
      r_pc        <= RESET_PC;
      r_pc_out    <= '0;
      r_opcode    <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_dest      <= '0;
      r_imm       <= '0;
      r_valid     <= 1'b0;
      r_issue_cnt <= ISSUE_CNT_INIT;
    end else begin
      r_valid <= (w_next_state == ST_ISSUE);

      if (w_flush) begin
        r_pc <= branch_target;
      end else if (w_ack) begin
        r_pc <= r_pc + ADDR_W'(1);
      end

      if (w_ack && (r_state == ST_REQ_INSTR)) begin
        r_opcode <= w_dec_opcode;
        r_s1     <= w_dec_s1;
        r_s2     <= w_dec_s2;
        r_dest   <= w_dec_dest;
        r_pc_out <= r_pc;
        r_imm    <= '0;
      end

      if (w_ack && (r_state == ST_REQ_IMM)) begin
        r_imm <= imem_data;
      end

      if (w_issue_fire && (r_issue_cnt != CNT_MAX)) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
    end
  end

  assign imem_addr    = r_pc;
  assign valid_out    = r_valid;
  assign opcode_out   = r_opcode;
  assign s1_out       = r_s1;
  assign s2_out       = r_s2;
  assign dest_out     = r_dest;
  assign ime_data_out = r_imm;
  assign pc_out       = r_pc_out;
  assign issue_cnt    = r_issue_cnt;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed phases push expected fetches
// and issues; negedge monitors pop and compare whenever the DUT presents them.
module tb_fetch_controller;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dest;
    logic [31:0] imm;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } issue_t;

  logic        clk_r = 1'b0;
  logic        reset_n_r = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        valid_out;
  logic [4:0]  opcode_out;
  logic [3:0]  s1_out, s2_out, dest_out;
  logic [31:0] ime_data_out;
  logic [7:0]  pc_out;
  logic [15:0] issue_cnt;

  logic        s_req, s_valid;
  logic [7:0]  s_addr, s_pc;
  logic [4:0]  s_op;
  logic [3:0]  s_s1, s_s2, s_dest;
  logic [31:0] s_imm;
  logic [15:0] s_cnt;

  logic [31:0] mem [256];
  int          ack_grant = 0;
  int          ack_taken = 0;
  int          ack_wait  = 0;
  int          wait_cnt;

  issue_t      q_issue [$];
  logic [7:0]  q_addr  [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_valid = 1'b0;

  always #5 clk_r = ~clk_r;

  fetch_controller u_dut (
    .clk_r         (clk_r),
    .reset_n_r     (reset_n_r),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .stall_in      (stall_in),
    .flush_in      (flush_in),
    .branch_target (branch_target),
    .valid_out     (valid_out),
    .opcode_out    (opcode_out),
    .s1_out        (s1_out),
    .s2_out        (s2_out),
    .dest_out      (dest_out),
    .ime_data_out  (ime_data_out),
    .pc_out        (pc_out),
    .issue_cnt     (issue_cnt)
  );

  // Free-running instance with the counter preloaded near saturation.
  fetch_controller #(.ISSUE_CNT_INIT(16'hFFFD)) u_sat (
    .clk_r         (clk_r),
    .reset_n_r     (reset_n_r),
    .imem_req      (s_req),
    .imem_addr     (s_addr),
    .imem_ack      (s_req),
    .imem_data     (32'h0800_0000),
    .stall_in      (1'b0),
    .flush_in      (1'b0),
    .branch_target (8'h00),
    .valid_out     (s_valid),
    .opcode_out    (s_op),
    .s1_out        (s_s1),
    .s2_out        (s_s2),
    .dest_out      (s_dest),
    .ime_data_out  (s_imm),
    .pc_out        (s_pc),
    .issue_cnt     (s_cnt)
  );

  // Memory model: acknowledges only granted fetches, after ack_wait idle cycles.
  assign imem_data = mem[imem_addr];
  assign imem_ack  = imem_req && (ack_taken < ack_grant) && (wait_cnt >= ack_wait);

  always @(posedge clk_r) begin
    if (imem_req && imem_ack) ack_taken <= ack_taken + 1;
  end

  always @(posedge clk_r or negedge reset_n_r) begin
    if (!reset_n_r)                wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [4:0] op, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] dest, input logic [31:0] imm,
                              input logic [7:0] pc, input logic [15:0] cnt);
    q_issue.push_back('{op: op, s1: s1, s2: s2, dest: dest, imm: imm, pc: pc, cnt: cnt});
  endtask

  always @(negedge clk_r) begin
    issue_t act;
    if (reset_n_r && imem_req && imem_ack && !flush_in) begin
      if (q_addr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL fetch_addr: got unexpected fetch at %0h expected none", imem_addr);
      end else begin
        check("fetch_addr", 128'(imem_addr), 128'(q_addr.pop_front()));
      end
    end
    if (reset_n_r && valid_out && !prev_valid) begin
      act = {opcode_out, s1_out, s2_out, dest_out, ime_data_out, pc_out, issue_cnt};
      if (q_issue.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL issue: got unexpected issue %0h expected none", act);
      end else begin
        check("issue", 128'(act), 128'(q_issue.pop_front()));
      end
    end
    prev_valid = valid_out;
  end

  task automatic do_reset();
    @(posedge clk_r); #1;
    reset_n_r = 1'b0;
    stall_in  = 1'b0;
    flush_in  = 1'b0;
    @(negedge clk_r);
    check("rst_req", 128'(imem_req), 128'(0));
    check("rst_addr", 128'(imem_addr), 128'(0));
    check("rst_outputs", 128'({valid_out, opcode_out, s1_out, s2_out, dest_out,
                               ime_data_out, pc_out, issue_cnt}), 128'(0));
    check("rst_sat_cnt", 128'(s_cnt), 128'(16'hFFFD));
    @(posedge clk_r); #1;
    reset_n_r = 1'b1;
    @(negedge clk_r);
    check("idle_no_req", 128'(imem_req), 128'(0));
    @(posedge clk_r); #1;
    check("first_req", 128'({imem_req, imem_addr}), 128'({1'b1, 8'h00}));
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!valid_out && n < max_cycles) begin
      @(negedge clk_r);
      n++;
    end
    check("valid_timeout", 128'(valid_out), 128'(1));
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((q_issue.size() != 0 || q_addr.size() != 0) && n < max_cycles) begin
      @(negedge clk_r);
      n++;
    end
    check("drain", 128'(q_issue.size() + q_addr.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h1A00_0000;
    mem[8'h41] = 32'h2D1E_0000;
    mem[8'hFF] = 32'h8A00_0000;

    // Non-immediate instruction with a zero-wait acknowledge.
    mem[0]    = 32'h1A00_0000;
    ack_wait  = 0;
    ack_grant = ack_grant + 1;
    q_addr.push_back(8'h00);
    expect_issue(5'd3, 4'd4, 4'd0, 4'd0, 32'h0, 8'h00, 16'd0);
    do_reset();
    drain(20);
    @(posedge clk_r); #1;
    check("after_first", 128'({imem_req, imem_addr, issue_cnt}), 128'({1'b1, 8'h01, 16'd1}));

    // Immediate instruction: two fetches, one wait cycle each.
    mem[0] = 32'h8000_0000;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h2D1E_0000;
    do_reset();
    ack_wait  = 1;
    ack_grant = ack_grant + 2;
    q_addr.push_back(8'h00);
    q_addr.push_back(8'h01);
    expect_issue(5'd16, 4'd0, 4'd0, 4'd0, 32'hDEAD_BEEF, 8'h00, 16'd0);
    drain(30);
    @(posedge clk_r); #1;
    check("after_imm", 128'({imem_req, imem_addr, issue_cnt}), 128'({1'b1, 8'h02, 16'd1}));

    // Stall holds the issued instruction and suppresses fetching.
    stall_in  = 1'b1;
    ack_wait  = 0;
    ack_grant = ack_grant + 1;
    q_addr.push_back(8'h02);
    expect_issue(5'd5, 4'hA, 4'h3, 4'hC, 32'h0, 8'h02, 16'd1);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_r);
      check("stall_hold", 128'({valid_out, imem_req, pc_out, opcode_out, issue_cnt}),
            128'({1'b1, 1'b0, 8'h02, 5'd5, 16'd1}));
    end
    @(posedge clk_r); #1;
    stall_in = 1'b0;
    @(posedge clk_r); #1;
    check("stall_release", 128'({imem_req, imem_addr, issue_cnt}), 128'({1'b1, 8'h03, 16'd2}));

    // Flush coincident with an acknowledge: the ack is discarded.
    flush_in      = 1'b1;
    branch_target = 8'h40;
    ack_grant     = ack_grant + 1;
    @(posedge clk_r); #1;
    flush_in = 1'b0;
    check("flush_redirect", 128'({imem_req, imem_addr, valid_out, issue_cnt, pc_out}),
          128'({1'b1, 8'h40, 1'b0, 16'd2, 8'h02}));
    ack_grant = ack_grant + 1;
    q_addr.push_back(8'h40);
    expect_issue(5'd3, 4'd4, 4'd0, 4'd0, 32'h0, 8'h40, 16'd2);
    drain(20);

    // Flush during a stalled issue drops the instruction uncounted.
    stall_in  = 1'b1;
    ack_grant = ack_grant + 1;
    q_addr.push_back(8'h41);
    expect_issue(5'd5, 4'hA, 4'h3, 4'hC, 32'h0, 8'h41, 16'd3);
    wait_valid(20);
    @(posedge clk_r); #1;
    flush_in      = 1'b1;
    branch_target = 8'hFF;
    @(posedge clk_r); #1;
    flush_in = 1'b0;
    stall_in = 1'b0;
    check("flush_over_stall", 128'({valid_out, imem_req, imem_addr, issue_cnt, pc_out}),
          128'({1'b0, 1'b1, 8'hFF, 16'd3, 8'h41}));

    // Immediate instruction at the top address wraps to 0 for its immediate.
    mem[0]    = 32'h1234_5678;
    ack_wait  = 1;
    ack_grant = ack_grant + 2;
    q_addr.push_back(8'hFF);
    q_addr.push_back(8'h00);
    expect_issue(5'd17, 4'd4, 4'd0, 4'd0, 32'h1234_5678, 8'hFF, 16'd3);
    drain(30);
    @(posedge clk_r); #1;
    check("after_wrap", 128'({imem_req, imem_addr, issue_cnt}), 128'({1'b1, 8'h01, 16'd4}));

    repeat (20) @(negedge clk_r);
    check("sat_cnt", 128'(s_cnt), 128'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
